// File: rtl/exc_pkg.sv
// Shared types and cause codes for the LEGv8 exception sequencer.
// Imported by the controller top and its bench.
package exc_pkg;

    typedef enum logic [1:0] {
        RUN,
        TAKE,
        HANDLER,
        RETURN
    } exc_state_t;

    localparam logic [3:0] ES_NONE     = 4'h0;
    localparam logic [3:0] ES_INVOP    = 4'h2;
    localparam logic [3:0] ES_ERET     = 4'h3;
    localparam logic [3:0] ES_IRQ_BASE = 4'h8;

    function automatic logic [3:0] irq_code(input logic [2:0] id);
        return ES_IRQ_BASE | {1'b0, id};
    endfunction

endpackage

// File: rtl/exc_controller_irq_prio_enc.sv
// Fixed-priority encoder for enabled interrupt lines.
// Lowest-numbered active request wins.
module irq_prio_enc #(
    parameter int NIRQ = 4
) (
    input  logic [NIRQ-1:0] req_i,
    output logic            valid_o,
    output logic [2:0]      id_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/exc_controller.sv
// Exception/interrupt sequencer driving Exc/ERet/EStatus
// of the single-cycle LEGv8 datapath.
module exc_controller
    import exc_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            invalid_op,
    input  logic            eret_instr,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    input  logic            ExcAck,
    output logic            Exc,
    output logic            ERet,
    output logic [3:0]      EStatus,
    output logic [NIRQ-1:0] irq_mask,
    output logic            in_handler,
    output logic            double_fault,
    output logic [7:0]      exc_count
);

    exc_state_t      state_q, state_d;
    logic [3:0]      es_q, es_d;
    logic [NIRQ-1:0] mask_q;
    logic [7:0]      cnt_q, cnt_d;
    logic            df_q, df_d;
    logic            irq_vld;
    logic [2:0]      irq_id;

    irq_prio_enc #(
        .NIRQ(NIRQ)
    ) u_prio (
        .req_i  (irq & mask_q),
        .valid_o(irq_vld),
        .id_o   (irq_id)
    );

    always_comb begin
        state_d = state_q;
        es_d    = es_q;
        cnt_d   = cnt_q;
        df_d    = df_q | (invalid_op && (state_q != RUN));
        unique case (state_q)
            RUN: begin
                if (invalid_op) begin
                    state_d = TAKE;
                    es_d    = ES_INVOP;
                end else if (eret_instr) begin
                    state_d = TAKE;
                    es_d    = ES_ERET;
                end else if (irq_vld) begin
                    state_d = TAKE;
                    es_d    = irq_code(irq_id);
                end
            end
            TAKE: begin
                if (ExcAck) begin
                    state_d = HANDLER;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            HANDLER: begin
                // A faulting instruction is not an ERET; it only flags the fault.
                if (eret_instr && !invalid_op) state_d = RETURN;
            end
            RETURN: begin
                state_d = RUN;
                es_d    = ES_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            es_q    <= ES_NONE;
            mask_q  <= '0;
            cnt_q   <= 8'd0;
            df_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            es_q    <= es_d;
            cnt_q   <= cnt_d;
            df_q    <= df_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign Exc          = (state_q == TAKE);
    assign ERet         = (state_q == RETURN);
    assign EStatus      = es_q;
    assign irq_mask     = mask_q;
    assign in_handler   = (state_q != RUN);
    assign double_fault = df_q;
    assign exc_count    = cnt_q;

endmodule
